serial_parity_checker: RTL and testbench

- Downstream consumer of the XOR-gate stage: receives a serial bit stream, one bit per accepted transfer, and reassembles it into frames.
- Each frame is DATA_BITS data bits, sent LSB first, followed by one parity bit.
- A running XOR across the frame gives the parity result. The block presents the recovered word plus a parity-error flag on a valid/ready output.
- Sits between the bit-level gate logic and any word-level consumer, such as a display or register file.

---
 rtl/serial_parity_pkg.sv | 18 +
 rtl/xor_accum.sv | 37 +++
 rtl/serial_parity_checker.sv | 161 ++++++++++++++++
 tb/tb_serial_parity_checker.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_parity_pkg.sv
// Shared types and constants for the serial parity checker slice.
package serial_parity_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    PARITY  = 2'd1,
    HOLD    = 2'd2
  } state_e;

  localparam int         ERR_CNT_W   = 8;
  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

  // Two-input XOR gate primitive shared with the upstream gate stage.
  function automatic logic xor2(input logic a, input logic b);
    return a ^ b;
  endfunction

endpackage

// File: rtl/xor_accum.sv
// One-bit running-XOR accumulator: toggles on (en & d), synchronous clear,
// asynchronous active-low reset.
module xor_accum
  import serial_parity_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic d,
  output logic q
);

  logic acc_q;
  logic acc_d;

  // Next accumulator value: clear wins over toggle.
  always_comb begin
    if (clr) begin
      acc_d = 1'b0;
    end else begin
      acc_d = xor2(acc_q, en & d);
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign q = acc_q;

endmodule

// File: rtl/serial_parity_checker.sv
// Reassembles LSB-first serial frames (DATA_BITS data + 1 parity) into words
// with a parity-error flag. Optional macro SERIAL_PARITY_ERR_COUNT_EN adds err_count.
module serial_parity_checker
  import serial_parity_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_bit,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_parity_err,
  output logic                 busy
`ifdef SERIAL_PARITY_ERR_COUNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_count
`endif
);

  localparam int             CW       = $clog2(DATA_BITS);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic           PAR_INV  = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] out_data_q, out_data_d;
  logic                 perr_q, perr_d;
  logic                 out_valid_q, out_valid_d;
  logic                 in_ready_q, in_ready_d;
  logic                 busy_q, busy_d;
  logic                 acc_s;
  logic                 acc_en_s;
  logic                 acc_clr_s;
  logic                 in_fire_s;
  logic                 out_fire_s;

  assign in_fire_s  = in_valid & in_ready_q;
  assign out_fire_s = out_valid_q & out_ready;

  xor_accum u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (acc_clr_s),
    .en    (acc_en_s),
    .d     (in_bit),
    .q     (acc_s)
  );

  // Frame FSM next-state; handshake outputs are derived from the next state
  // so they can be registered without a cycle of lag.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    out_data_d = out_data_q;
    perr_d     = perr_q;
    acc_en_s   = 1'b0;
    acc_clr_s  = 1'b0;
    case (state_q)
      COLLECT: begin
        if (in_fire_s) begin
          shreg_d[cnt_q] = in_bit;
          acc_en_s       = 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = PARITY;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          state_d = COLLECT;
        end
      end
      PARITY: begin
        if (in_fire_s) begin
          out_data_d = shreg_q;
          perr_d     = xor2(acc_s, in_bit) ^ PAR_INV;
          state_d    = HOLD;
        end else begin
          state_d = PARITY;
        end
      end
      HOLD: begin
        if (out_fire_s) begin
          acc_clr_s = 1'b1;
          state_d   = COLLECT;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = COLLECT;
        cnt_d   = '0;
      end
    endcase
    out_valid_d = (state_d == HOLD);
    in_ready_d  = (state_d != HOLD);
    busy_d      = (state_d != COLLECT) || (cnt_d != '0);
  end

  // Frame state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      shreg_q     <= '0;
      out_data_q  <= '0;
      perr_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      out_data_q  <= out_data_d;
      perr_q      <= perr_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_parity_err = perr_q;
  assign busy           = busy_q;

`ifdef SERIAL_PARITY_ERR_COUNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Saturating count of frames delivered with a parity error.
  always_comb begin
    if (out_fire_s && perr_q && (err_cnt_q != ERR_CNT_MAX)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Error counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_serial_parity_checker.sv
// Directed scoreboard bench for serial_parity_checker: an even-parity and an
// odd-parity instance share the stimulus; sel picks which one is driven/observed.
`timescale 1ns/1ps
module tb_serial_parity_checker;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_bit, out_ready;
  int   sel;
  int   checks = 0;
  int   errors = 0;
  logic [8:0] sb[$];
  int   exp_cnt[2];

  logic in_ready_e, out_valid_e, perr_e, busy_e;
  logic in_ready_o, out_valid_o, perr_o, busy_o;
  logic [7:0] out_data_e, out_data_o;
  logic in_valid_e, in_valid_o, out_ready_e, out_ready_o;
  logic ir, ov, pe, bz;
  logic [7:0] od;
`ifdef SERIAL_PARITY_ERR_COUNT_EN
  logic [7:0] err_count_e, err_count_o, ec;
  assign ec = (sel == 1) ? err_count_o : err_count_e;
`endif

  always #5 clk = ~clk;

  assign in_valid_e  = in_valid & (sel == 0);
  assign in_valid_o  = in_valid & (sel == 1);
  assign out_ready_e = out_ready & (sel == 0);
  assign out_ready_o = out_ready & (sel == 1);
  assign ir = (sel == 1) ? in_ready_o  : in_ready_e;
  assign ov = (sel == 1) ? out_valid_o : out_valid_e;
  assign pe = (sel == 1) ? perr_o      : perr_e;
  assign bz = (sel == 1) ? busy_o      : busy_e;
  assign od = (sel == 1) ? out_data_o  : out_data_e;

  serial_parity_checker #(.DATA_BITS(8), .PARITY_ODD(0)) dut_e (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_e), .in_ready(in_ready_e),
    .in_bit(in_bit), .out_valid(out_valid_e), .out_ready(out_ready_e),
    .out_data(out_data_e), .out_parity_err(perr_e), .busy(busy_e)
`ifdef SERIAL_PARITY_ERR_COUNT_EN
    , .err_count(err_count_e)
`endif
  );

  serial_parity_checker #(.DATA_BITS(8), .PARITY_ODD(1)) dut_o (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_o), .in_ready(in_ready_o),
    .in_bit(in_bit), .out_valid(out_valid_o), .out_ready(out_ready_o),
    .out_data(out_data_o), .out_parity_err(perr_o), .busy(busy_o)
`ifdef SERIAL_PARITY_ERR_COUNT_EN
    , .err_count(err_count_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; presents one bit for the following rising edge.
  task automatic send_bit(input logic b);
    in_valid = 1'b1;
    in_bit   = b;
    @(negedge clk);
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input int gap);
    logic err;
    for (int i = 0; i < 8; i++) begin
      send_bit(d[i]);
      repeat (gap) @(negedge clk);
    end
    chk("ready_before_parity", ir, 1);
    send_bit(p);
    if (sel == 1) err = ($countones({p, d}) % 2) == 0;
    else          err = ($countones({p, d}) % 2) == 1;
    sb.push_back({err, d});
    chk("latency_out_valid", ov, 1);
  endtask

  task automatic take_frame(input string tag);
    int n;
    logic [8:0] e;
    n = 0;
    while (ov !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, ov, 1);
    chk({tag, "_sb_nonempty"}, (sb.size() > 0) ? 1 : 0, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_data"}, od, e[7:0]);
      chk({tag, "_perr"}, pe, e[8]);
      if (e[8] && exp_cnt[sel] < 255) exp_cnt[sel]++;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_valid_after"}, ov, 0);
    chk({tag, "_ready_after"}, ir, 1);
    chk({tag, "_busy_after"}, bz, 0);
`ifdef SERIAL_PARITY_ERR_COUNT_EN
    chk({tag, "_err_count"}, ec, exp_cnt[sel]);
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0; sel = 0;
    exp_cnt[0] = 0; exp_cnt[1] = 0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", ir, 1);
    chk("rst_out_valid", ov, 0);
    chk("rst_out_data", od, 0);
    chk("rst_perr", pe, 0);
    chk("rst_busy", bz, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Stray out_ready while idle must do nothing.
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_out_ready_valid", ov, 0);
    chk("idle_out_ready_busy", bz, 0);

    send_frame(8'hA5, 1'b0, 0);
    chk("hold_busy", bz, 1);
    chk("hold_in_ready", ir, 0);
    take_frame("even_ok");

    send_frame(8'hA5, 1'b1, 0);
    take_frame("even_err");

    sel = 1;
    send_frame(8'h07, 1'b0, 0);
    take_frame("odd_ok");
    send_frame(8'h07, 1'b1, 0);
    take_frame("odd_err");
    sel = 0;

    send_frame(8'hA5, 1'b0, 3);
    take_frame("gaps");

    // Backpressure: bits offered during HOLD must be refused.
    send_frame(8'hC3, 1'b1, 0);
    in_valid = 1'b1;
    in_bit   = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", ov, 1);
      chk("bp_data", od, 8'hC3);
      chk("bp_in_ready", ir, 0);
    end
    in_valid = 1'b0;
    in_bit   = 1'b0;
    take_frame("backpressure");

    // Asynchronous reset mid-frame.
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    chk("mid_busy", bz, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", bz, 0);
    chk("arst_valid", ov, 0);
    chk("arst_data", od, 0);
    chk("arst_perr", pe, 0);
    chk("arst_in_ready", ir, 1);
    exp_cnt[0] = 0; exp_cnt[1] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", ov, 0);
    send_frame(8'h3C, 1'b0, 0);
    take_frame("after_reset");

`ifdef SERIAL_PARITY_ERR_COUNT_EN
    for (int f = 0; f < 260; f++) begin
      send_frame(8'h01, 1'b0, 0);
      take_frame("sat");
    end
    chk("sat_final", ec, 8'd255);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
